// File: rtl/cspc_port_gather_pkg.sv
// Helpers shared by the CSPC gather stage and the major-clock interface:
// ceiling log2 for pointer/occupancy sizing and the port-slice packing rule.
package cspc_port_gather_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Port i occupies bits [i*width +: width] of every packed port bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/cspc_gather_fifo.sv
// Per-port synchronous FIFO: head is a combinational read of the storage array,
// occupancy is held explicitly so full/empty come straight from registers.
module cspc_gather_fifo
  import cspc_port_gather_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= data_in;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  assign data_out = mem_reg[rd_ptr_reg];
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/cspc_port_gather.sv
// Gathers NUM_PORTS independent streams into one aligned parallel word once
// every port FIFO holds data; single flow-controlled output register.
module cspc_port_gather
  import cspc_port_gather_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]       avail_in,
  output logic [NUM_PORTS-1:0]       ready_in,
  output logic [NUM_PORTS*WIDTH-1:0] data_outarray,
  output logic                       avail_outarray,
  input  logic                       ready_outarray,
  output logic [COUNT_WIDTH-1:0]     gather_count
);

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0]       full_vec;
  logic [NUM_PORTS-1:0]       empty_vec;
  logic [NUM_PORTS*WIDTH-1:0] head_flat;
  // Per-port occupancy is only observed in simulation/debug.
  logic [NUM_PORTS*CNT_W-1:0] occupancy_unused;

  logic [NUM_PORTS*WIDTH-1:0] data_out_reg;
  logic                       avail_out_reg;
  logic [COUNT_WIDTH-1:0]     gather_count_reg;
  logic                       out_free;
  logic                       fire;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      cspc_gather_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (avail_in[gi] & ready_in[gi]),
        .pop     (fire),
        .data_in (data_in[slice_lo(gi, WIDTH) +: WIDTH]),
        .data_out(head_flat[slice_lo(gi, WIDTH) +: WIDTH]),
        .full    (full_vec[gi]),
        .empty   (empty_vec[gi]),
        .count   (occupancy_unused[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Ready depends only on registered occupancy, never on ready_outarray.
  assign ready_in = ~full_vec & {NUM_PORTS{~rst}};

  assign out_free = ~avail_out_reg | ready_outarray;
  assign fire     = (&(~empty_vec)) & out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg     <= '0;
      avail_out_reg    <= 1'b0;
      gather_count_reg <= '0;
    end else if (fire) begin
      data_out_reg     <= head_flat;
      avail_out_reg    <= 1'b1;
      gather_count_reg <= gather_count_reg + COUNT_WIDTH'(1);
    end else if (ready_outarray) begin
      avail_out_reg <= 1'b0;
    end
  end

  assign data_outarray  = data_out_reg;
  assign avail_outarray = avail_out_reg;
  assign gather_count   = gather_count_reg;

endmodule

// File: tb/tb_cspc_port_gather.sv
// Randomised and directed bench for cspc_port_gather against a queue-based
// transaction model of the per-port buffering and the output stage.
module tb_cspc_port_gather;

  localparam int NP = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*W-1:0]   data_in = '0;
  logic [NP-1:0]     avail_in = '0;
  logic [NP-1:0]     ready_in;
  logic [NP*W-1:0]   data_outarray;
  logic              avail_outarray;
  logic              ready_outarray = 1'b1;
  logic [CW-1:0]     gather_count;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per port plus the visible output state.
  logic [W-1:0]    mq [NP][$];
  logic [NP*W-1:0] m_data = '0;
  logic            m_avail = 1'b0;
  int              m_cnt = 0;

  // Source side: a word offered but not yet accepted must be held.
  logic            pend_v [NP];
  logic [W-1:0]    pend_d [NP];
  int              seq    [NP];

  cspc_port_gather #(
    .NUM_PORTS  (NP),
    .WIDTH      (W),
    .DEPTH      (D),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .avail_in      (avail_in),
    .ready_in      (ready_in),
    .data_outarray (data_outarray),
    .avail_outarray(avail_outarray),
    .ready_outarray(ready_outarray),
    .gather_count  (gather_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] exp_ready(input logic r);
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = !r && (mq[i].size() < D);
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [NP-1:0] av,
                            input logic [NP*W-1:0] din, input logic rdy,
                            output logic [NP-1:0] acc);
    bit all_have;
    acc = '0;
    if (r) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      m_avail = 1'b0;
      m_data  = '0;
      m_cnt   = 0;
      return;
    end
    all_have = 1'b1;
    for (int i = 0; i < NP; i++) begin
      acc[i] = av[i] && (mq[i].size() < D);
      if (mq[i].size() == 0) all_have = 1'b0;
    end
    if (all_have && (!m_avail || rdy)) begin
      for (int i = 0; i < NP; i++) m_data[i*W +: W] = mq[i].pop_front();
      m_avail = 1'b1;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (rdy) begin
      m_avail = 1'b0;
    end
    for (int i = 0; i < NP; i++) if (acc[i]) mq[i].push_back(din[i*W +: W]);
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input logic r, input logic [NP-1:0] want, input logic rdy);
    logic [NP-1:0] acc;
    for (int i = 0; i < NP; i++) begin
      if (!pend_v[i] && want[i]) begin
        pend_v[i] = 1'b1;
        pend_d[i] = W'(seq[i] * NP + i);
        seq[i]++;
      end
    end
    rst = r;
    ready_outarray = rdy;
    for (int i = 0; i < NP; i++) begin
      avail_in[i] = pend_v[i];
      data_in[i*W +: W] = pend_d[i];
    end
    #1;
    check_eq("ready_in", 64'(ready_in), 64'(exp_ready(r)));
    check_eq("avail_outarray", 64'(avail_outarray), 64'(m_avail));
    check_eq("data_outarray", data_outarray, m_data);
    check_eq("gather_count", 64'(gather_count), 64'(m_cnt));
    @(posedge clk);
    model_edge(r, avail_in, data_in, rdy, acc);
    for (int i = 0; i < NP; i++) if (acc[i]) pend_v[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
      seq[i]    = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset held with every port offering data
    for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 1'b1);
    // Single gather: push {3,2,1,0}, visible two cycles later
    step(1'b0, 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    check_eq("single_avail", 64'(avail_outarray), 64'd1);
    check_eq("single_data", data_outarray, 64'h0003_0002_0001_0000);
    check_eq("single_count", 64'(gather_count), 64'd1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);

    // Starved port 3
    step(1'b1, 4'h0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 4'b0111, 1'b1);
    check_eq("starve_ready", 64'(ready_in), 64'b1000);
    check_eq("starve_avail", 64'(avail_outarray), 64'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1000, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 4'h0, 1'b1);

    // Backpressure
    step(1'b1, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 4'hF, 1'b0);
    check_eq("bp_ready", 64'(ready_in), 64'd0);
    check_eq("bp_avail", 64'(avail_outarray), 64'd1);
    for (int k = 0; k < 10; k++) step(1'b0, 4'hF, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 4'h0, 1'b1);

    // Full throughput with counter wrap: 20 gathers from reset
    step(1'b1, 4'h0, 1'b1);
    for (int k = 0; k <= 20; k++) begin
      step(1'b0, (k < 20) ? 4'hF : 4'h0, 1'b1);
      if (k >= 1) check_eq("thru_avail", 64'(avail_outarray), 64'd1);
    end
    check_eq("wrap_count", 64'(gather_count), 64'd4);
    step(1'b0, 4'h0, 1'b1);

    // Reset mid-operation with words queued and output valid
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 1'b0);
    check_eq("mid_avail_before", 64'(avail_outarray), 64'd1);
    step(1'b1, 4'h0, 1'b0);
    check_eq("mid_avail_after", 64'(avail_outarray), 64'd0);
    check_eq("mid_count_after", 64'(gather_count), 64'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 4'h0, 1'b1);
    check_eq("mid_no_ghost", 64'(gather_count), 64'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           NP'($urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
